// File: rtl/accel_pkg.sv
// Shared constants and FSM state encoding for the accelerometer scaling front end.
package accel_pkg;
  localparam int RAW_W = 20;
  localparam int SCALED_W = 24;
  localparam logic [SCALED_W-1:0] SCALED_MAX = 24'hFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    AX_X,
    AX_Y,
    AX_Z,
    OUT
  } state_e;
endpackage

// File: rtl/accel_axis_calc.sv
// Per-axis datapath: baseline subtract, magnitude, gain shift with saturation,
// and the next EMA baseline. Purely combinational, shared across X/Y/Z.
module accel_axis_calc
  import accel_pkg::*;
#(
  parameter int RAW_W      = accel_pkg::RAW_W,
  parameter int EMA_K      = 6,
  parameter int GAIN_SHIFT = 4
) (
  input  logic [RAW_W-1:0]         raw,
  input  logic [RAW_W+EMA_K:0]     base_fx,
  output logic [SCALED_W-1:0]      scaled,
  output logic [RAW_W+EMA_K:0]     base_fx_next
);
  localparam int BW = RAW_W + EMA_K + 1;
  localparam int DW = RAW_W + 2;
  localparam int MW = DW + GAIN_SHIFT;

  logic [DW-1:0] diff;
  logic [DW-1:0] mag;
  logic [MW-1:0] wide;

  // base_fx[BW-1:EMA_K] is the arithmetic right shift of the baseline
  assign diff = {{2{raw[RAW_W-1]}}, raw} - {base_fx[BW-1], base_fx[BW-1:EMA_K]};
  assign mag  = diff[DW-1] ? (~diff + DW'(1)) : diff;
  assign wide = MW'(mag) << GAIN_SHIFT;

  generate
    if (MW > SCALED_W) begin : g_sat
      assign scaled = (|wide[MW-1:SCALED_W]) ? SCALED_MAX : wide[SCALED_W-1:0];
    end else begin : g_fit
      assign scaled = SCALED_W'(wide);
    end
  endgenerate

  assign base_fx_next = base_fx + {{(BW-DW){diff[DW-1]}}, diff};
endmodule

// File: rtl/accel_scaler.sv
// Accelerometer conditioning: EMA baseline removal, magnitude, gain and settle gating.
// Build option: ACCEL_SCALER_TRACK_EN keeps baselines tracking after settling.
//
// state | meaning
// IDLE  | ready for a raw triplet; capture on valid
// AX_X  | X axis through shared datapath
// AX_Y  | Y axis through shared datapath
// AX_Z  | Z axis through shared datapath
// OUT   | publish scaled triplet, pulse valid, advance settle count
module accel_scaler
  import accel_pkg::*;
#(
  parameter int RAW_W          = accel_pkg::RAW_W,
  parameter int EMA_K          = 6,
  parameter int GAIN_SHIFT     = 4,
  parameter int SETTLE_SAMPLES = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_sample_valid,
  output logic                    o_sample_ready,
  input  logic signed [RAW_W-1:0] i_xdata_raw,
  input  logic signed [RAW_W-1:0] i_ydata_raw,
  input  logic signed [RAW_W-1:0] i_zdata_raw,
  output logic [SCALED_W-1:0]     o_xdata_scaled,
  output logic [SCALED_W-1:0]     o_ydata_scaled,
  output logic [SCALED_W-1:0]     o_zdata_scaled,
  output logic                    o_scaled_valid,
  output logic                    o_settled
);
  localparam int BW = RAW_W + EMA_K + 1;
  localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_SAMPLES);

  state_e              state;
  logic [RAW_W-1:0]    raw_x, raw_y, raw_z;
  logic [BW-1:0]       base_x, base_y, base_z;
  logic [SCALED_W-1:0] sc_x, sc_y, sc_z;
  logic                preloaded;
  logic [15:0]         settle_left;

  logic [RAW_W-1:0]    calc_raw;
  logic [BW-1:0]       calc_base;
  logic [SCALED_W-1:0] calc_scaled;
  logic [BW-1:0]       calc_next;
  logic                upd_en;

  always_comb begin
    calc_raw  = raw_x;
    calc_base = base_x;
    case (state)
      AX_Y: begin calc_raw = raw_y; calc_base = base_y; end
      AX_Z: begin calc_raw = raw_z; calc_base = base_z; end
      default: ;
    endcase
  end

`ifdef ACCEL_SCALER_TRACK_EN
  assign upd_en = 1'b1;
`else
  // baselines freeze once calibrated so a sustained offset stays visible
  assign upd_en = ~o_settled;
`endif

  accel_axis_calc #(
    .RAW_W      (RAW_W),
    .EMA_K      (EMA_K),
    .GAIN_SHIFT (GAIN_SHIFT)
  ) u_calc (
    .raw          (calc_raw),
    .base_fx      (calc_base),
    .scaled       (calc_scaled),
    .base_fx_next (calc_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      o_sample_ready <= 1'b1;
      o_scaled_valid <= 1'b0;
      o_settled      <= 1'b0;
      o_xdata_scaled <= '0;
      o_ydata_scaled <= '0;
      o_zdata_scaled <= '0;
      raw_x          <= '0;
      raw_y          <= '0;
      raw_z          <= '0;
      base_x         <= '0;
      base_y         <= '0;
      base_z         <= '0;
      sc_x           <= '0;
      sc_y           <= '0;
      sc_z           <= '0;
      preloaded      <= 1'b0;
      settle_left    <= SETTLE_INIT;
    end else begin
      o_scaled_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_sample_valid) begin
            raw_x <= i_xdata_raw;
            raw_y <= i_ydata_raw;
            raw_z <= i_zdata_raw;
            // first sample seeds the baseline so its diff is exactly zero
            if (!preloaded) begin
              base_x <= {i_xdata_raw[RAW_W-1], i_xdata_raw, {EMA_K{1'b0}}};
              base_y <= {i_ydata_raw[RAW_W-1], i_ydata_raw, {EMA_K{1'b0}}};
              base_z <= {i_zdata_raw[RAW_W-1], i_zdata_raw, {EMA_K{1'b0}}};
            end
            preloaded      <= 1'b1;
            o_sample_ready <= 1'b0;
            state          <= AX_X;
          end
        end
        AX_X: begin
          sc_x <= calc_scaled;
          if (upd_en) base_x <= calc_next;
          state <= AX_Y;
        end
        AX_Y: begin
          sc_y <= calc_scaled;
          if (upd_en) base_y <= calc_next;
          state <= AX_Z;
        end
        AX_Z: begin
          sc_z <= calc_scaled;
          if (upd_en) base_z <= calc_next;
          state <= OUT;
        end
        OUT: begin
          o_xdata_scaled <= o_settled ? sc_x : '0;
          o_ydata_scaled <= o_settled ? sc_y : '0;
          o_zdata_scaled <= o_settled ? sc_z : '0;
          o_scaled_valid <= 1'b1;
          // settle count runs down to zero and stays there
          if (settle_left == 16'd1) o_settled <= 1'b1;
          if (settle_left != 16'd0) settle_left <= settle_left - 16'd1;
          o_sample_ready <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          o_sample_ready <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_accel_scaler.sv
// Randomized bench for accel_scaler with an arithmetic reference model; a second
// instance with a larger gain exercises the saturation path.
module tb_accel_scaler;
  localparam int SETTLE = 64;
  localparam int EMA_K  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, valid;
  logic signed [19:0] xr, yr, zr;
  logic ready, sv, settled;
  logic [23:0] xs, ys, zs;
  logic ready_h, sv_h, settled_h;
  logic [23:0] xs_h, ys_h, zs_h;

  accel_scaler #(.RAW_W(20), .EMA_K(EMA_K), .GAIN_SHIFT(4), .SETTLE_SAMPLES(SETTLE)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_sample_valid(valid), .o_sample_ready(ready),
    .i_xdata_raw(xr), .i_ydata_raw(yr), .i_zdata_raw(zr),
    .o_xdata_scaled(xs), .o_ydata_scaled(ys), .o_zdata_scaled(zs),
    .o_scaled_valid(sv), .o_settled(settled));

  accel_scaler #(.RAW_W(20), .EMA_K(EMA_K), .GAIN_SHIFT(8), .SETTLE_SAMPLES(SETTLE)) u_hi (
    .i_clk(clk), .i_rst(rst), .i_sample_valid(valid), .o_sample_ready(ready_h),
    .i_xdata_raw(xr), .i_ydata_raw(yr), .i_zdata_raw(zr),
    .o_xdata_scaled(xs_h), .o_ydata_scaled(ys_h), .o_zdata_scaled(zs_h),
    .o_scaled_valid(sv_h), .o_settled(settled_h));

  typedef struct {
    longint due;
    logic [2:0][23:0] lo;
    logic [2:0][23:0] hi;
    bit settled;
  } exp_t;

  exp_t   q[$];
  longint cyc = 0, free_at = 0;
  bit     chk_en = 0;
  longint base[3];
  bit     pre, m_settled, exp_settled;
  int     cnt;
  logic [2:0][23:0] hold_lo, hold_hi;
  int     n_vec = 0, n_mis = 0, n_acc = 0;

  function automatic logic [23:0] sat(longint v);
    logic [63:0] t;
    t = v;
    return (v > 64'hFFFFFF) ? 24'hFFFFFF : t[23:0];
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // reference model: plain integer EMA per axis, evaluated at each accept
  task automatic model_accept();
    exp_t e;
    longint rv[3];
    longint bi, diff, mag;
    rv[0] = xr; rv[1] = yr; rv[2] = zr;
    e.due = cyc + 5;
    for (int a = 0; a < 3; a++) begin
      if (!pre) base[a] = rv[a] * 64;
      bi   = base[a] >>> EMA_K;
      diff = rv[a] - bi;
      mag  = (diff < 0) ? -diff : diff;
      e.lo[a] = m_settled ? sat(mag * 16) : 24'h0;
      e.hi[a] = m_settled ? sat(mag * 256) : 24'h0;
`ifdef ACCEL_SCALER_TRACK_EN
      base[a] += diff;
`else
      if (!m_settled) base[a] += diff;
`endif
    end
    pre = 1;
    if (cnt < SETTLE) cnt++;
    m_settled = (cnt == SETTLE);
    e.settled = m_settled;
    q.push_back(e);
    free_at = cyc + 5;
  endtask

  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) begin
        hold_lo = q[0].lo; hold_hi = q[0].hi; exp_settled = q[0].settled;
        void'(q.pop_front());
      end
      check("ready",      ready,     cyc >= free_at);
      check("ready_hi",   ready_h,   cyc >= free_at);
      check("valid",      sv,        ev);
      check("valid_hi",   sv_h,      ev);
      check("settled",    settled,   exp_settled);
      check("settled_hi", settled_h, exp_settled);
      check("x",    xs,   hold_lo[0]);
      check("y",    ys,   hold_lo[1]);
      check("z",    zs,   hold_lo[2]);
      check("x_hi", xs_h, hold_hi[0]);
      check("y_hi", ys_h, hold_hi[1]);
      check("z_hi", zs_h, hold_hi[2]);
    end
    if (rst) begin
      chk_en = 1; free_at = cyc + 1; q.delete();
      pre = 0; cnt = 0; m_settled = 0; exp_settled = 0;
      hold_lo = '0; hold_hi = '0;
      for (int a = 0; a < 3; a++) base[a] = 0;
    end else if (chk_en && valid && cyc >= free_at) begin
      n_acc++;
      model_accept();
    end
    cyc++;
  end

  task automatic send(input logic signed [19:0] x, input logic signed [19:0] y,
                      input logic signed [19:0] z, input int gap);
    int t;
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    xr = x; yr = y; zr = z; valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ready && t < 20) begin @(negedge clk); t++; end
    if (!ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_pulse();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!sv && t < 12);
    if (!sv) check("pulse_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int a0, pulses;
    rst = 1'b1; valid = 1'b0; xr = '0; yr = '0; zr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_settled", settled, 0);
    check("rst_x", xs, 0);

    // calibration on a constant triplet: zero outputs, settle on the 64th pulse
    for (int i = 0; i < SETTLE; i++) begin
      send(20'sd100, -20'sd50, 20'sh40000, 0);
      wait_pulse();
      check("cal_x", xs, 0);
      check("cal_z", zs, 0);
      if (i == SETTLE - 2) check("settled_early", settled, 0);
      if (i == SETTLE - 1) check("settled_64", settled, 1);
    end

    send(20'sd100 + 20'sh1000, -20'sd50, 20'sh40000, 0);
    wait_pulse();
    check("step_x", xs, 24'h010000);
    check("step_y", ys, 24'h0);
    check("step_z", zs, 24'h0);
    check("step_x_hi", xs_h, 24'h100000);

    // valid held high with changing data: one accept every 5 cycles
    @(posedge clk); #1;
    valid = 1'b1; a0 = n_acc;
    repeat (50) begin
      xr = 20'($urandom); yr = 20'($urandom); zr = 20'($urandom);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("accepts_per_50", n_acc - a0, 10);
    repeat (8) @(negedge clk);

    // reset while the triplet is in AX_Y: no pulse for it
    send(20'sd7, 20'sd8, 20'sd9, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    pulses = 0;
    repeat (8) begin @(negedge clk); if (sv) pulses++; end
    check("midreset_pulses", pulses, 0);
    check("midreset_settled", settled, 0);

    // settle at extreme baselines, then swing to the opposite rail
    for (int i = 0; i < SETTLE; i++) begin
      send(-20'sh80000, 20'sd0, 20'sh7FFFF, 0);
      wait_pulse();
    end
    send(20'sh7FFFF, 20'sh100, -20'sh80000, 0);
    wait_pulse();
    check("rail_x", xs, 24'hFFFFF0);
    check("rail_z", zs, 24'hFFFFF0);
    check("rail_y", ys, 24'h001000);
    check("rail_x_hi", xs_h, 24'hFFFFFF);
    check("rail_z_hi", zs_h, 24'hFFFFFF);
    check("rail_y_hi", ys_h, 24'h010000);

`ifndef ACCEL_SCALER_TRACK_EN
    // frozen baseline keeps a sustained offset visible
    do_reset();
    for (int i = 0; i < SETTLE; i++) begin
      send(20'sd0, 20'sd0, 20'sd0, 0);
      wait_pulse();
    end
    for (int i = 0; i < 200; i++) begin
      send(20'sh100, 20'sd0, 20'sd0, 0);
      wait_pulse();
      check("frozen_x", xs, 24'h001000);
    end
`endif

    // random drift around a random offset, then full-range values
    do_reset();
    begin
      int ox, oy, oz;
      ox = $urandom_range(0, 400000) - 200000;
      oy = $urandom_range(0, 400000) - 200000;
      oz = $urandom_range(0, 400000) - 200000;
      for (int i = 0; i < 150; i++) begin
        if (i < 100)
          send(20'(ox + int'($urandom_range(0, 2000)) - 1000),
               20'(oy + int'($urandom_range(0, 2000)) - 1000),
               20'(oz + int'($urandom_range(0, 2000)) - 1000), $urandom_range(0, 3));
        else
          send(20'($urandom), 20'($urandom), 20'($urandom), $urandom_range(0, 3));
      end
    end
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
